// File: rtl/prefix_sum_stage.sv
// prefix_sum_stage: final stage of the prefix adder.
// Retimes the propagate vector and carry-in so they line up with the
// tree's group-carry output, forms sum/cout/ovf/zero, and holds the
// result in an output register with a valid/ready handshake.
//
// Ports:
//   clkpos     clock, rising-edge
//   rstn       asynchronous active-low reset
//   p_in       bit propagate (a ^ b), presented at tree launch
//   cin_in     carry-in, presented with p_in
//   launch     operand pair enters the tree this cycle
//   g_in       group carry from last tree row (g_in[i] = carry out of bit i)
//   hold       combinational: freeze tree and operand source this cycle
//   sum        registered sum
//   cout       registered carry out
//   ovf        registered signed overflow
//   zero       registered sum == 0
//   out_valid  output register holds a result
//   out_ready  consumer accepts the result
//   op_count   (PREFIX_SUM_OPCOUNT_EN only) saturating count of transfers
//
// Optional feature macro: PREFIX_SUM_OPCOUNT_EN
module prefix_sum_stage #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 5
) (
  input  logic         clkpos,
  input  logic         rstn,
  input  logic [W-1:0] p_in,
  input  logic         cin_in,
  input  logic         launch,
  input  logic [W-1:0] g_in,
  output logic         hold,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         out_valid,
  input  logic         out_ready
`ifdef PREFIX_SUM_OPCOUNT_EN
  ,
  output logic [15:0]  op_count
`endif
);

  localparam int unsigned TAIL = DEPTH - 1;

  logic         adv;
  logic [W-1:0] p_q   [DEPTH];
  logic         cin_q [DEPTH];
  logic         tag_q [DEPTH];
  logic [W-1:0] sum_c;
  logic         zero_c;
  logic         ovf_c;

  // The whole stage, delay line included, advances only when the output
  // register can take a new value.
  assign adv  = !out_valid || out_ready;
  assign hold = !adv;

  // Delay line head.
  always_ff @(posedge clkpos or negedge rstn) begin
    if (!rstn) begin
      p_q[0]   <= '0;
      cin_q[0] <= 1'b0;
      tag_q[0] <= 1'b0;
    end else if (adv) begin
      p_q[0]   <= p_in;
      cin_q[0] <= cin_in;
      tag_q[0] <= launch;
    end
  end

  // Delay line body: entry k follows entry k-1.
  for (genvar k = 1; k < DEPTH; k++) begin : g_dly
    always_ff @(posedge clkpos or negedge rstn) begin
      if (!rstn) begin
        p_q[k]   <= '0;
        cin_q[k] <= 1'b0;
        tag_q[k] <= 1'b0;
      end else if (adv) begin
        p_q[k]   <= p_q[k-1];
        cin_q[k] <= cin_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  // Sum bit i uses the carry into bit i: cin for bit 0, g_in[i-1] above.
  always_comb begin
    sum_c  = p_q[TAIL] ^ {g_in[W-2:0], cin_q[TAIL]};
    zero_c = (sum_c == '0);
    ovf_c  = g_in[W-1] ^ g_in[W-2];
  end

  // Output register; flags only load when the tail carries a real operation.
  always_ff @(posedge clkpos or negedge rstn) begin
    if (!rstn) begin
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= tag_q[TAIL];
      if (tag_q[TAIL]) begin
        sum  <= sum_c;
        cout <= g_in[W-1];
        ovf  <= ovf_c;
        zero <= zero_c;
      end
    end
  end

`ifdef PREFIX_SUM_OPCOUNT_EN
  // Saturating count of accepted results.
  always_ff @(posedge clkpos or negedge rstn) begin
    if (!rstn) begin
      op_count <= 16'h0000;
    end else if (out_valid && out_ready && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prefix_sum_stage.sv
// Testbench for prefix_sum_stage: emulates the upstream tree (which freezes
// on hold), drives random and directed operands, and checks results via a
// scoreboard of arithmetic reference values popped by a monitor.
module tb_prefix_sum_stage;

  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 5;

  typedef longint unsigned u64_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    bit           v;
  } op_t;

  logic         clkpos = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] p_in = '0;
  logic         cin_in = 1'b0;
  logic         launch = 1'b0;
  logic [W-1:0] g_in = '0;
  logic         hold;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         out_valid;
  logic         out_ready = 1'b0;
`ifdef PREFIX_SUM_OPCOUNT_EN
  logic [15:0]  op_count;
`endif

  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;
  res_t sb[$];
  op_t  tree[DEPTH];

  prefix_sum_stage #(.W(W), .DEPTH(DEPTH)) dut (
    .clkpos   (clkpos),
    .rstn     (rstn),
    .p_in     (p_in),
    .cin_in   (cin_in),
    .launch   (launch),
    .g_in     (g_in),
    .hold     (hold),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf),
    .zero     (zero),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef PREFIX_SUM_OPCOUNT_EN
    ,
    .op_count (op_count)
`endif
  );

  always #5 clkpos = ~clkpos;

  // Reference result from plain integer arithmetic.
  function automatic res_t calc(logic [W-1:0] a, logic [W-1:0] b, logic ci);
    res_t   r;
    u64_t   t;
    longint ts;
    t  = u64_t'(a) + u64_t'(b) + u64_t'(ci);
    ts = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (ts > 64'sd2147483647) || (ts < -64'sd2147483648);
    r.zero = (t[W-1:0] == '0);
    return r;
  endfunction

  // What the tree would produce: carry out of each bit position.
  function automatic logic [W-1:0] carries(logic [W-1:0] a, logic [W-1:0] b, logic ci);
    logic [W-1:0] c;
    for (int i = 0; i < W; i++) begin
      u64_t m;
      u64_t t;
      m = (u64_t'(1) << (i + 1)) - u64_t'(1);
      t = (u64_t'(a) & m) + (u64_t'(b) & m) + u64_t'(ci);
      c[i] = t[i+1];
    end
    return c;
  endfunction

  task automatic clear_tree();
    for (int k = 0; k < DEPTH; k++) tree[k] = '{a: '0, b: '0, ci: 1'b0, v: 1'b0};
  endtask

  // One clock of upstream activity; returns after the rising edge.
  task automatic cycle(input bit do_l, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input bit rdy, output bit taken);
    bit adv_b;
    @(negedge clkpos);
    out_ready = rdy;
    g_in = tree[DEPTH-1].v ? carries(tree[DEPTH-1].a, tree[DEPTH-1].b, tree[DEPTH-1].ci)
                           : W'($urandom);
    #1;
    adv_b = !hold;
    taken = adv_b && do_l;
    launch = taken;
    p_in   = a ^ b;
    cin_in = ci;
    if (taken) sb.push_back(calc(a, b, ci));
    @(posedge clkpos);
    if (adv_b) begin
      for (int k = DEPTH - 1; k > 0; k--) tree[k] = tree[k-1];
      tree[0] = '{a: a, b: b, ci: ci, v: taken};
    end
  endtask

  task automatic idle(input bit rdy);
    bit t;
    cycle(1'b0, '0, '0, 1'b0, rdy, t);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0) && (n < 60)) begin
      idle(1'b1);
      n++;
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL drain pending=%0d required=0", sb.size());
      errors++;
      sb.delete();
    end
  endtask

  // Launch into an empty pipe and measure edges until out_valid.
  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    bit t;
    int n;
    drain();
    cycle(1'b1, a, b, ci, 1'b1, t);
    n = 1;
    #1;
    while (!out_valid && n < 20) begin
      idle(1'b1);
      n++;
      #1;
    end
    checks++;
    if (!t || n != DEPTH + 1) begin
      $display("FAIL latency a=%h b=%h edges=%0d required=%0d", a, b, n, DEPTH + 1);
      errors++;
    end
  endtask

  // Monitor: hold consistency, stall stability, and scoreboard pops on transfer.
  bit   stall_prev = 1'b0;
  res_t held;
  always @(negedge clkpos) begin
    #3;
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      checks++;
      if (hold !== (out_valid && !out_ready)) begin
        $display("FAIL hold got=%b required=%b", hold, out_valid && !out_ready);
        errors++;
      end
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || sum !== held.sum || cout !== held.cout ||
            ovf !== held.ovf || zero !== held.zero) begin
          $display("FAIL stall_stable got=%b/%h/%b%b%b required=1/%h/%b%b%b", out_valid, sum,
                   cout, ovf, zero, held.sum, held.cout, held.ovf, held.zero);
          errors++;
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_result got sum=%h required no output", sum);
          errors++;
        end else begin
          res_t e;
          e = sb.pop_front();
          if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf || zero !== e.zero) begin
            $display("FAIL result got sum=%h c=%b v=%b z=%b required sum=%h c=%b v=%b z=%b",
                     sum, cout, ovf, zero, e.sum, e.cout, e.ovf, e.zero);
            errors++;
          end
        end
        if (xfers < 65535) xfers++;
      end
      stall_prev = out_valid && !out_ready;
      held = '{sum: sum, cout: cout, ovf: ovf, zero: zero};
    end
  end

  initial begin
    bit t;
    int n;
    int hold_cnt;
    int seen;
    logic [W-1:0] a;
    logic [W-1:0] b;
    clear_tree();

    // Reset values with no clock edge needed.
    #1;
    checks++;
    if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0 || out_valid !== 1'b0) begin
      $display("FAIL reset_values got=%h/%b%b%b/%b required=0/000/0", sum, cout, ovf, zero, out_valid);
      errors++;
    end
    repeat (2) @(posedge clkpos);
    @(negedge clkpos);
    rstn = 1'b1;

    // Directed: basic add, wrap-to-zero, signed overflow.
    directed(32'h0000_0005, 32'h0000_0003, 1'b0);
    directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    directed(32'h8000_0000, 32'h8000_0000, 1'b0);
    directed(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    drain();

    // Backpressure: 4 back-to-back launches, consumer stalls 3 cycles.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1, t);
      checks++;
      if (!t) begin
        $display("FAIL bp_launch idx=%0d got=not_taken required=taken", i);
        errors++;
      end
    end
    n = 0;
    #1;
    while (!out_valid && n < 20) begin
      idle(1'b0);
      n++;
      #1;
    end
    hold_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      idle(1'b0);
      if (hold === 1'b1) hold_cnt++;
    end
    checks++;
    if (hold_cnt != 3) begin
      $display("FAIL bp_hold got=%0d required=3", hold_cnt);
      errors++;
    end
    drain();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: begin a = 32'hFFFF_FFFF; b = W'($urandom_range(0, 2)); end
        1: begin a = 32'h7FFF_FFFF; b = W'($urandom_range(0, 2)); end
        2: begin a = W'($urandom); b = ~a; end
        default: begin a = W'($urandom); b = W'($urandom); end
      endcase
      cycle($urandom_range(0, 9) < 7, a, b, 1'($urandom), $urandom_range(0, 9) < 7, t);
    end
    drain();

    // Reset mid-stream discards in-flight work.
    for (int i = 0; i < 3; i++) cycle(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1, t);
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1, t);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (sum !== '0 || out_valid !== 1'b0 || hold !== 1'b0) begin
      $display("FAIL mid_reset got sum=%h v=%b hold=%b required 0/0/0", sum, out_valid, hold);
      errors++;
    end
    sb.delete();
    clear_tree();
    launch = 1'b0;
    repeat (2) @(posedge clkpos);
    @(negedge clkpos);
    rstn = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      idle(1'b1);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      $display("FAIL post_reset_output got=%0d required=0", seen);
      errors++;
    end

`ifdef PREFIX_SUM_OPCOUNT_EN
    // Counter restarts from zero after reset; 10 transfers then saturation.
    for (int i = 0; i < 10; i++) cycle(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1, t);
    drain();
    checks++;
    if (op_count !== 16'(xfers)) begin
      $display("FAIL op_count got=%0d required=%0d", op_count, xfers);
      errors++;
    end
    for (int i = 0; i < 65540; i++) cycle(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1, t);
    drain();
    checks++;
    if (op_count !== 16'hFFFF) begin
      $display("FAIL op_count_sat got=%h required=ffff", op_count);
      errors++;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Mid-reset resets the bench transfer count alongside the DUT counter.
  always @(negedge rstn) xfers = 0;

endmodule

// File: doc/prefix_sum_stage.md
Name: prefix_sum_stage

Overview:
- Final stage of the MIPS25 adiabatic prefix adder. It sits directly downstream of the last black/gray-cell row.
- It takes the tree's group-generate (carry) vector and retimes the per-bit propagate vector and cin so they line up with it.
- It forms sum, cout, signed overflow and zero, and holds them in an output register with a valid/ready handshake.
- Clocked digital companion to the power-clocked tree; clocked on clkpos.

Parameters:
- W, 32, operand width in bits (W >= 2).
- DEPTH, 5, tree latency in clkpos cycles from operand launch to g_in valid (DEPTH >= 1).

Ports:
- clkpos  input  1  clock; all state updates on rising edge.
- rstn  input  1  asynchronous active-low reset.
- p_in  input  W  bit propagate (a ^ b), presented at tree launch.
- cin_in  input  1  carry-in, presented with p_in.
- launch  input  1  operand pair enters the tree this cycle.
- g_in  input  W  group carry from the last tree row; g_in[i] = carry out of bit i, with cin already folded in.
- hold  output  1  freeze the tree and operand source this cycle.
- sum  output  W  registered sum.
- cout  output  1  registered carry out.
- ovf  output  1  registered signed overflow.
- zero  output  1  registered sum == 0.
- out_valid  output  1  output register holds a result.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset, async on rstn low, no clock needed:
  - sum = 0, cout = 0, ovf = 0, zero = 0, out_valid = 0.
  - Delay line cleared: all p, cin and tag entries = 0.
- Advance signal: adv = !out_valid || out_ready. hold = !adv, combinational.
- Upstream contract: while hold = 1, the tree and operand source freeze, and launch/g_in are ignored.
- Delay line: DEPTH entries of {p, cin, tag}. On each edge with adv = 1:
  - entry 0 <= {p_in, cin_in, launch};
  - entry k <= entry k-1.
  - With adv = 0, the whole line holds.
- Alignment: the tail entry (DEPTH-1) and g_in belong to the same operation. g_in is sampled only when the tail tag = 1 and adv = 1.
- Result computation (tail entry {pt, ct}):
  - s[0] = pt[0] ^ ct; s[i] = pt[i] ^ g_in[i-1] for i >= 1.
  - cout = g_in[W-1].
  - ovf = g_in[W-1] ^ g_in[W-2].
  - zero = (s == 0).
- Output register, on an edge with adv = 1:
  - out_valid <= tail tag.
  - If tail tag = 1, load sum/cout/ovf/zero.
  - If tail tag = 0, flags and sum hold their old values, but out_valid falls.
- Latency:
  - A result appears DEPTH+1 edges after the launch edge, when there are no stalls.
  - Throughput is one result per cycle.
- Stall: out_valid = 1 and out_ready = 0. Output, delay line and hold = 1 persist until out_ready is seen high.
- Simultaneous: out_ready = 1 while a new tail tag = 1 arrives gives back-to-back transfer on the same edge, with no bubble.
- Reset mid-operation discards every in-flight operation; no partial result is ever presented.
- Width rules: no truncation; all vectors are W bits; cout and ovf are separate bits.

Optional Feature:
- Macro: PREFIX_SUM_OPCOUNT_EN.
- Defined:
  - Adds output op_count (16 bits).
  - Increments on every edge with out_valid && out_ready.
  - Saturates at 16'hFFFF.
  - Cleared by rstn.
- Undefined: no port and no counter logic; behaviour otherwise identical.

Test Plan:
- Reset check: rstn low mid-stream with DEPTH = 5, W = 32 -> sum = 0, out_valid = 0 immediately. No output 6 edges after release without a new launch.
- Basic add: a = 0x0000_0005, b = 0x0000_0003, cin = 0, out_ready = 1 -> sum = 0x0000_0008, cout = 0, ovf = 0, zero = 0, out_valid exactly 6 edges after launch.
- Wrap-around and zero: a = 0xFFFF_FFFF, b = 0x0000_0001 -> sum = 0, cout = 1, zero = 1, ovf = 0.
- Signed overflow: a = 0x7FFF_FFFF, b = 0x0000_0001 -> sum = 0x8000_0000, ovf = 1, cout = 0.
- Backpressure: 4 back-to-back launches, out_ready low for 3 cycles when the first result is valid -> hold = 1 for those cycles, first result held stable, all 4 results delivered in order with no loss or duplication.
- Counter (PREFIX_SUM_OPCOUNT_EN defined): 10 accepted transfers -> op_count = 10. Force 65540 transfers -> op_count = 16'hFFFF.
